// File: rtl/rosc_meas_pkg.sv
// rtl/rosc_meas_pkg.sv - shared state type and mask helpers for the rosc measurement sequencer
package rosc_meas_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_START, S_RUN, S_STOP, S_SETTLE, S_SAMPLE, S_SEND, S_NEXT
  } state_t;

  localparam int MASK_MAX = 32;

  function automatic int cnt_bytes(input int cnt_w);
    return cnt_w / 8;
  endfunction

  // -1 when the mask is empty
  function automatic int lowest_set(input logic [MASK_MAX-1:0] mask);
    int idx;
    idx = -1;
    for (int i = MASK_MAX - 1; i >= 0; i--)
      if (mask[i]) idx = i;
    return idx;
  endfunction

  function automatic int next_set_above(input logic [MASK_MAX-1:0] mask, input int from);
    int idx;
    idx = -1;
    for (int i = MASK_MAX - 1; i >= 0; i--)
      if (mask[i] && i > from) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/rosc_count_sampler.sv
// rtl/rosc_count_sampler.sv - samples a timer count until two consecutive reads agree
module rosc_count_sampler #(
  parameter int CNT_W       = 32,
  parameter int MAX_SAMPLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [CNT_W-1:0] count,
  output logic             stable,
  output logic             give_up,
  output logic             err,
  output logic [CNT_W-1:0] value
);

  localparam int N_W = $clog2(MAX_SAMPLES + 1);

  logic [N_W-1:0]   n_taken;
  logic [CNT_W-1:0] prev;

  assign stable  = sample_en && (n_taken != '0) && (count == prev);
  assign give_up = sample_en && !stable && (n_taken == N_W'(MAX_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_taken <= '0;
      prev    <= '0;
      err     <= 1'b0;
      value   <= '0;
    end else if (sample_en) begin
      prev    <= count;
      n_taken <= n_taken + 1'b1;
      if (stable || give_up) begin
        value <= count;
        err   <= give_up;
      end
    end else begin
      n_taken <= '0;
    end
  end

endmodule

// File: rtl/rosc_meas_sequencer.sv
// rtl/rosc_meas_sequencer.sv - sweeps rosc timers: clear, timed window, stop, stable capture, byte stream
module rosc_meas_sequencer
  import rosc_meas_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 32,
  parameter int WIN_W         = 16,
  parameter int CLEAR_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_SAMPLES   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic                      abort,
  input  logic                      continuous,
  input  logic [WIN_W-1:0]          cfg_window,
  input  logic [NUM_CH-1:0]         cfg_ch_mask,
  input  logic [NUM_CH*CNT_W-1:0]   t_count,
  output logic [NUM_CH-1:0]         t_clear,
  output logic [NUM_CH-1:0]         t_start,
  output logic [NUM_CH-1:0]         t_stop,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      out_err,
  output logic                      busy,
  output logic                      done
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int N_BYTES = cnt_bytes(CNT_W);
  localparam int B_W     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  state_t            state, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [WIN_W-1:0]  win_q, win_d, cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [B_W-1:0]    byte_q, byte_d;
  logic              sweep_end;
  int                nxt;
  logic              smp_stable, smp_give_up, smp_err;
  logic [CNT_W-1:0]  smp_value;
  logic [NUM_CH-1:0] ch_onehot;

  rosc_count_sampler #(
    .CNT_W       (CNT_W),
    .MAX_SAMPLES (MAX_SAMPLES)
  ) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (state == S_SAMPLE),
    .count     (t_count[ch_q*CNT_W +: CNT_W]),
    .stable    (smp_stable),
    .give_up   (smp_give_up),
    .err       (smp_err),
    .value     (smp_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mask_q <= '0;
      win_q  <= '0;
      cnt_q  <= '0;
      ch_q   <= '0;
      byte_q <= '0;
    end else begin
      state  <= state_d;
      mask_q <= mask_d;
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      ch_q   <= ch_d;
      byte_q <= byte_d;
    end
  end

  always_comb begin
    state_d   = state;
    mask_d    = mask_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    byte_d    = byte_q;
    sweep_end = 1'b0;
    nxt       = -1;
    case (state)
      S_IDLE: if (go && cfg_ch_mask != '0) begin
        mask_d  = cfg_ch_mask;
        win_d   = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
        ch_d    = CH_W'(lowest_set(MASK_MAX'(cfg_ch_mask)));
        cnt_d   = '0;
        state_d = S_CLEAR;
      end
      S_CLEAR: if (cnt_q == WIN_W'(CLEAR_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = S_START;
      end else cnt_d = cnt_q + 1'b1;
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      // win_q is at least 1, so win_q-1 never underflows
      S_RUN: if (cnt_q == win_q - 1'b1) begin
        cnt_d   = '0;
        state_d = S_STOP;
      end else cnt_d = cnt_q + 1'b1;
      S_STOP: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: if (cnt_q == WIN_W'(SETTLE_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = S_SAMPLE;
      end else cnt_d = cnt_q + 1'b1;
      S_SAMPLE: if (smp_stable || smp_give_up) begin
        byte_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: if (out_ready) begin
        if (byte_q == B_W'(N_BYTES - 1)) state_d = S_NEXT;
        else byte_d = byte_q + 1'b1;
      end
      S_NEXT: begin
        nxt   = next_set_above(MASK_MAX'(mask_q), int'(ch_q));
        cnt_d = '0;
        if (nxt >= 0) begin
          ch_d    = CH_W'(nxt);
          state_d = S_CLEAR;
        end else if (continuous) begin
          ch_d    = CH_W'(lowest_set(MASK_MAX'(mask_q)));
          state_d = S_CLEAR;
        end else begin
          sweep_end = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  assign ch_onehot = NUM_CH'(1) << ch_q;
  assign t_clear   = (state == S_CLEAR) ? ch_onehot : '0;
  assign t_start   = (state == S_START) ? ch_onehot : '0;
  assign t_stop    = (state == S_STOP)  ? ch_onehot : '0;
  assign busy      = (state != S_IDLE);
  assign done      = sweep_end && !abort;
  assign out_valid = (state == S_SEND);
  assign out_data  = out_valid ? smp_value[{byte_q, 3'b000} +: 8] : 8'h00;
  assign out_ch    = out_valid ? ch_q : '0;
  assign out_last  = out_valid && (byte_q == B_W'(N_BYTES - 1));
  assign out_err   = out_valid && smp_err;

endmodule

// File: tb/tb_rosc_meas_sequencer.sv
// tb/tb_rosc_meas_sequencer.sv - randomized self-checking bench for rosc_meas_sequencer
module tb_rosc_meas_sequencer;

  localparam int SETTLE = 3;
  localparam int LOGN   = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         go, abort, continuous;
  logic [15:0]  cfg_window;
  logic [3:0]   cfg_ch_mask;
  logic [127:0] t_count;
  logic [3:0]   t_clear, t_start, t_stop;
  logic         out_valid, out_ready;
  logic [7:0]   out_data;
  logic [1:0]   out_ch;
  logic         out_last, out_err, busy, done;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  bit           rdy_rand = 1'b0;
  logic [3:0]   unstable = 4'b0;
  logic [31:0]  cur [4];
  logic [31:0]  cnt_log [LOGN][4];

  rosc_meas_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .abort       (abort),
    .continuous  (continuous),
    .cfg_window  (cfg_window),
    .cfg_ch_mask (cfg_ch_mask),
    .t_count     (t_count),
    .t_clear     (t_clear),
    .t_start     (t_start),
    .t_stop      (t_stop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .out_err     (out_err),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock: inputs change just after the edge, outputs are read at the falling edge
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    go        = 1'b0;
    abort     = 1'b0;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (unstable[c]) cur[c] = cur[c] + 32'($urandom_range(1, 1000));
      t_count[32*c +: 32]     = cur[c];
      cnt_log[cyc % LOGN][c]  = cur[c];
    end
    @(negedge clk);
  endtask

  function automatic int top_bit(input logic [3:0] m);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (m[i]) r = i;
    return r;
  endfunction

  task automatic measure(input int ch, input int w, input bit exp_done, input bit drop);
    int          stop_cyc, b, guard;
    logic [3:0]  oh;
    logic [31:0] exp_val;
    bit          bad;
    oh = 4'(1 << ch);
    tick();
    if (drop) continuous = 1'b0;
    chk_eq("clear_c0", 32'({t_clear, t_start, t_stop}), 32'({oh, 8'h00}));
    tick();
    chk_eq("clear_c1", 32'({t_clear, t_start, t_stop}), 32'({oh, 8'h00}));
    tick();
    chk_eq("start", 32'({t_clear, t_start, t_stop}), 32'({4'h0, oh, 4'h0}));
    bad = 1'b0;
    for (int i = 0; i < w; i++) begin
      tick();
      if ((t_clear | t_start | t_stop) != 4'h0) bad = 1'b1;
    end
    chk_eq("run_quiet", 32'(bad), 32'd0);
    tick();
    chk_eq("stop", 32'({t_clear, t_start, t_stop}), 32'({8'h00, oh}));
    stop_cyc = cyc;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!out_valid && guard < 60);
    chk_eq("first_valid_dly", 32'(cyc - stop_cyc), unstable[ch] ? 32'(SETTLE + 9) : 32'(SETTLE + 3));
    exp_val = unstable[ch] ? cnt_log[(stop_cyc + SETTLE + 8) % LOGN][ch] : cur[ch];
    b = 0;
    guard = 0;
    while (b < 4 && guard < 200) begin
      chk_eq("valid", 32'(out_valid), 32'd1);
      if (!out_valid) break;
      chk_eq("data", 32'(out_data), 32'(exp_val[8*b +: 8]));
      chk_eq("out_ch", 32'(out_ch), 32'(ch));
      chk_eq("err", 32'(out_err), 32'(unstable[ch]));
      chk_eq("last", 32'(out_last), 32'(b == 3));
      if (out_ready) b++;
      tick();
      guard++;
    end
    chk_eq("bytes", 32'(b), 32'd4);
    chk_eq("next_valid", 32'(out_valid), 32'd0);
    chk_eq("next_busy", 32'(busy), 32'd1);
    chk_eq("done", 32'(done), 32'(exp_done));
  endtask

  task automatic run_sweep(input logic [3:0] mask, input logic [15:0] win, input int n_sweeps);
    int w;
    w           = (win == 16'd0) ? 1 : int'(win);
    cfg_ch_mask = mask;
    cfg_window  = win;
    continuous  = (n_sweeps > 1);
    go          = 1'b1;
    for (int s = 0; s < n_sweeps; s++)
      for (int c = 0; c < 4; c++)
        if (mask[c]) begin
          measure(c, w, (s == n_sweeps - 1) && (c == top_bit(mask)),
                  (s == n_sweeps - 1) && (n_sweeps > 1));
          cfg_ch_mask = 4'($urandom);
          cfg_window  = 16'($urandom);
          go          = 1'($urandom_range(0, 1));
        end
    tick();
    chk_eq("end_busy", 32'(busy), 32'd0);
    chk_eq("end_done", 32'(done), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk_eq(tag, 32'({busy, done, out_valid, t_clear, t_start, t_stop, out_data}), 32'd0);
  endtask

  initial begin
    int  guard;
    bit  bad;
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; continuous = 1'b0;
    cfg_window = 16'd0; cfg_ch_mask = 4'd0; out_ready = 1'b1; t_count = '0;
    for (int c = 0; c < 4; c++) cur[c] = 32'h0;
    repeat (3) @(negedge clk);
    chk_quiet("reset_outs");
    chk_eq("reset_misc", 32'({out_ch, out_last, out_err}), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int c = 0; c < 4; c++) cur[c] = 32'h11223344;
    run_sweep(4'b0101, 16'd10, 1);
    rdy_rand = 1'b1;
    run_sweep(4'b1111, 16'd3, 1);
    unstable = 4'b0010;
    run_sweep(4'b0110, 16'd0, 1);
    unstable = 4'b0000;
    run_sweep(4'b1000, 16'd7, 3);
    run_sweep(4'b0011, 16'd2, 2);

    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) cur[c] = $urandom;
      unstable = 4'($urandom);
      run_sweep(4'($urandom_range(1, 15)), 16'($urandom_range(0, 25)), 1);
    end
    unstable = 4'b0000;

    cfg_ch_mask = 4'b0010; cfg_window = 16'd20; go = 1'b1;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    chk_quiet("abort_run");
    bad = 1'b0;
    repeat (3) begin tick(); if (busy || done) bad = 1'b1; end
    chk_eq("abort_run_idle", 32'(bad), 32'd0);

    cfg_ch_mask = 4'b0001; cfg_window = 16'd2; go = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (!out_valid && guard < 60);
    chk_eq("abort_send_reach", 32'(out_valid), 32'd1);
    out_ready = 1'b1; abort = 1'b1;
    tick();
    chk_quiet("abort_send");
    tick();
    chk_eq("abort_send_done", 32'({busy, done}), 32'd0);
    run_sweep(4'b0100, 16'd4, 1);

    cfg_ch_mask = 4'b1000; cfg_window = 16'd1; go = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (!out_valid && guard < 60);
    chk_eq("rst_send_reach", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_quiet("async_reset");
    chk_eq("async_reset_misc", 32'({out_ch, out_last, out_err}), 32'd0);
    tick();
    rst_n = 1'b1;

    cfg_ch_mask = 4'b0000; go = 1'b1;
    bad = 1'b0;
    repeat (5) begin tick(); if (busy || done) bad = 1'b1; end
    chk_eq("mask0_ignored", 32'(bad), 32'd0);
    for (int c = 0; c < 4; c++) cur[c] = $urandom;
    run_sweep(4'b1001, 16'd5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
